// File: rtl/rtcl_hs_tx_pack_pkg.sv
// Shared constants for the HS TX packer: header layout, framer state codes and CRC-16 helpers.
// The CRC helpers are only exercised when RTCL_HS_TX_PACK_CRC_EN is defined.
package rtcl_hs_tx_pack_pkg;

  localparam logic [7:0] SYNC_CODE = 8'hB8;

  localparam int HDR_SYNC_LSB  = 0;
  localparam int HDR_FRAME_BIT = 8;
  localparam int HDR_RSVD_BIT  = 9;
  localparam int HDR_LINE_LSB  = 10;
  localparam int HDR_MIN_BITS  = 26;

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE = 3'd0;
  localparam fsm_state_t ST_HEAD = 3'd1;
  localparam fsm_state_t ST_BODY = 3'd2;
  localparam fsm_state_t ST_TAIL = 3'd3;
  localparam fsm_state_t ST_DONE = 3'd4;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One serial CRC-16-CCITT step; beats are fed LSB first, one call per bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic data_bit);
    logic fb;
    fb = crc[15] ^ data_bit;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/rtcl_hs_tx_gearbox.sv
// Generic bit accumulator that repacks S_BITS beats into M_BITS words, LSB first,
// zero-padding the tail of each packet and marking its first and last words.
module rtcl_hs_tx_gearbox #(
  parameter int S_BITS = 40,
  parameter int M_BITS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              beat_first,
  input  logic              beat_last,
  input  logic [S_BITS-1:0] beat_data,
  input  logic              beat_valid,
  output logic              beat_ready,
  output logic              word_first,
  output logic              word_last,
  output logic [M_BITS-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready
);

  localparam int BUF_BITS = S_BITS + M_BITS;
  localparam int CNT_BITS = $clog2(BUF_BITS + 1);
  localparam logic [CNT_BITS-1:0] M_CNT = CNT_BITS'(M_BITS);
  localparam logic [CNT_BITS-1:0] S_CNT = CNT_BITS'(S_BITS);

  logic [BUF_BITS-1:0] acc;
  logic [BUF_BITS-1:0] acc_pop;
  logic [BUF_BITS-1:0] acc_next;
  logic [CNT_BITS-1:0] occ;
  logic [CNT_BITS-1:0] occ_pop;
  logic [CNT_BITS-1:0] occ_next;
  logic                first_pend;
  logic                last_pend;
  logic                have_word;
  logic                out_free;
  logic                pop;
  logic                push;
  logic                pop_is_last;

  // Readiness is judged on post-pop occupancy so a beat can land in the same
  // cycle a word leaves, which keeps the output busy every cycle.
  always_comb begin
    have_word   = (occ >= M_CNT) || (last_pend && (occ != '0));
    out_free    = !word_valid || word_ready;
    pop         = en && have_word && out_free;
    pop_is_last = last_pend && (occ <= M_CNT);
    occ_pop     = occ;
    acc_pop     = acc;
    if (pop) begin
      occ_pop = (occ >= M_CNT) ? (occ - M_CNT) : '0;
      acc_pop = acc >> M_BITS;
    end
    beat_ready = !last_pend && (occ_pop <= M_CNT);
    push       = en && beat_valid && beat_ready;
    acc_next   = acc_pop;
    occ_next   = occ_pop;
    if (push) begin
      acc_next = acc_pop | (BUF_BITS'(beat_data) << occ_pop);
      occ_next = occ_pop + S_CNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      occ        <= '0;
      first_pend <= 1'b0;
      last_pend  <= 1'b0;
      word_data  <= '0;
      word_valid <= 1'b0;
      word_first <= 1'b0;
      word_last  <= 1'b0;
    end else if (en) begin
      acc <= acc_next;
      occ <= occ_next;
      if (pop) begin
        first_pend <= 1'b0;
      end
      if (push && beat_first) begin
        first_pend <= 1'b1;
      end
      if (push && beat_last) begin
        last_pend <= 1'b1;
      end else if (pop && pop_is_last) begin
        last_pend <= 1'b0;
      end
      if (pop) begin
        word_data  <= acc[M_BITS-1:0];
        word_valid <= 1'b1;
        word_first <= first_pend;
        word_last  <= pop_is_last;
      end else if (word_ready) begin
        word_valid <= 1'b0;
        word_first <= 1'b0;
        word_last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rtcl_hs_tx_pack.sv
// HS TX packer: frames each input line as header + zero-stuffed payload and repacks it to D-PHY words.
// Define RTCL_HS_TX_PACK_CRC_EN to append a CRC-16-CCITT trailer beat to every packet.
module rtcl_hs_tx_pack
  import rtcl_hs_tx_pack_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int RAW_BITS       = 10,
  parameter int DPHY_LANES     = 2,
  parameter int LINE_BITS      = 16,
  parameter int STUFF_CNT_BITS = 16,
  parameter int S_BITS         = CHANNELS * RAW_BITS,
  parameter int M_BITS         = DPHY_LANES * 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      aclken,
  input  logic                      s_axi4s_tuser,
  input  logic                      s_axi4s_tlast,
  input  logic [S_BITS-1:0]         s_axi4s_tdata,
  input  logic                      s_axi4s_tvalid,
  output logic                      s_axi4s_tready,
  output logic                      m_axi4s_tuser,
  output logic                      m_axi4s_tlast,
  output logic [M_BITS-1:0]         m_axi4s_tdata,
  output logic                      m_axi4s_tvalid,
  input  logic                      m_axi4s_tready,
  output logic [LINE_BITS-1:0]      line_number,
  output logic [STUFF_CNT_BITS-1:0] stuff_count
);

  generate
    if (S_BITS < HDR_MIN_BITS) begin : g_width_check
      $error("rtcl_hs_tx_pack: S_BITS must be at least %0d", HDR_MIN_BITS);
    end
  endgenerate

  fsm_state_t state;
  fsm_state_t state_next;

  logic                 beat_valid;
  logic                 beat_first;
  logic                 beat_last;
  logic                 beat_ready;
  logic [S_BITS-1:0]    beat_data;
  logic [S_BITS-1:0]    header;
  logic [LINE_BITS-1:0] line_val;

`ifdef RTCL_HS_TX_PACK_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_next;

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < S_BITS; i++) begin
      crc_next = crc16_step(crc_next, beat_data[i]);
    end
  end
`endif

  always_comb begin
    line_val = s_axi4s_tuser ? '0 : line_number + 1'b1;
    header = '0;
    header[HDR_SYNC_LSB +: 8]        = SYNC_CODE;
    header[HDR_FRAME_BIT]            = s_axi4s_tuser;
    header[HDR_RSVD_BIT]             = 1'b0;
    header[HDR_LINE_LSB +: LINE_BITS] = line_val;
  end

  // BODY always offers a beat so the gearbox never starves mid-packet;
  // a missing input beat becomes an all-zero stuff beat.
  always_comb begin
    state_next     = state;
    beat_valid     = 1'b0;
    beat_first     = 1'b0;
    beat_last      = 1'b0;
    beat_data      = '0;
    s_axi4s_tready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_axi4s_tvalid) begin
          state_next = ST_HEAD;
        end
      end
      ST_HEAD: begin
        beat_valid = 1'b1;
        beat_first = 1'b1;
        beat_data  = header;
        if (beat_ready) begin
          state_next = ST_BODY;
        end
      end
      ST_BODY: begin
        beat_valid     = 1'b1;
        s_axi4s_tready = beat_ready;
        if (s_axi4s_tvalid) begin
          beat_data = s_axi4s_tdata;
        end
`ifdef RTCL_HS_TX_PACK_CRC_EN
        if (beat_ready && s_axi4s_tvalid && s_axi4s_tlast) begin
          state_next = ST_TAIL;
        end
`else
        beat_last = s_axi4s_tvalid && s_axi4s_tlast;
        if (beat_ready && s_axi4s_tvalid && s_axi4s_tlast) begin
          state_next = ST_DONE;
        end
`endif
      end
      ST_TAIL: begin
`ifdef RTCL_HS_TX_PACK_CRC_EN
        beat_valid      = 1'b1;
        beat_last       = 1'b1;
        beat_data[15:0] = crc;
        if (beat_ready) begin
          state_next = ST_DONE;
        end
`else
        state_next = ST_IDLE;
`endif
      end
      ST_DONE: begin
        // The gearbox holds off new beats until the padded tail word is out.
        if (beat_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      line_number <= '0;
      stuff_count <= '0;
    end else if (aclken) begin
      state <= state_next;
      if (state == ST_HEAD && beat_ready) begin
        line_number <= line_val;
        if (s_axi4s_tuser) begin
          stuff_count <= '0;
        end
      end
      if (state == ST_BODY && beat_ready && !s_axi4s_tvalid && stuff_count != '1) begin
        stuff_count <= stuff_count + 1'b1;
      end
    end
  end

`ifdef RTCL_HS_TX_PACK_CRC_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      crc <= CRC16_INIT;
    end else if (aclken) begin
      if (state == ST_HEAD && beat_ready) begin
        crc <= CRC16_INIT;
      end else if (state == ST_BODY && beat_ready) begin
        crc <= crc_next;
      end
    end
  end
`endif

  rtcl_hs_tx_gearbox #(
    .S_BITS(S_BITS),
    .M_BITS(M_BITS)
  ) u_gearbox (
    .clk       (aclk),
    .rst_n     (aresetn),
    .en        (aclken),
    .beat_first(beat_first),
    .beat_last (beat_last),
    .beat_data (beat_data),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .word_first(m_axi4s_tuser),
    .word_last (m_axi4s_tlast),
    .word_data (m_axi4s_tdata),
    .word_valid(m_axi4s_tvalid),
    .word_ready(m_axi4s_tready)
  );

endmodule
